// File: rtl/alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_arbiter_if
//   Bundle of every non-clock signal around the alu_arbiter: two requester
//   ports, the shared-ALU operand/result path, the result port and busy.
//
//   slave  : the arbiter's view (takes requests, drives the ALU and results).
//   master : the environment's view (requesters, external ALU, result consumer).
// -----------------------------------------------------------------------------
interface alu_arbiter_if;
    // Requester 0
    logic       req0_valid;
    logic [3:0] req0_a;
    logic [3:0] req0_b;
    logic [1:0] req0_op;
    logic       req0_ready;
    // Requester 1
    logic       req1_valid;
    logic [3:0] req1_a;
    logic [3:0] req1_b;
    logic [1:0] req1_op;
    logic       req1_ready;
    // Shared ALU
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_op;
    logic [3:0] alu_out;
    // Result port and status
    logic       res_valid;
    logic [3:0] res_data;
    logic       res_id;
    logic       res_ready;
    logic       busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req1_ready,
        output alu_a, alu_b, alu_op,
        input  alu_out,
        output res_valid, res_data, res_id,
        input  res_ready,
        output busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req1_ready,
        input  alu_a, alu_b, alu_op,
        output alu_out,
        input  res_valid, res_data, res_id,
        output res_ready,
        input  busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Shares one registered 4-bit ALU between two requesters. One operation is
//   in flight at a time: IDLE (grant) -> EXEC (ALU computes) -> CAPT (sample
//   alu_out) -> RESP (hold result until consumer accepts) -> IDLE.
//
//   Parameters
//     RR_EN : 1 = round-robin on contention, 0 = requester 0 always wins.
//   Ports
//     clk   : single clock, rising-edge.
//     rst_n : asynchronous active-low reset.
//     bus   : alu_arbiter_if.slave (requesters, ALU path, result, busy).
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_CAPT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] alu_a_q, alu_a_d;
    logic [3:0] alu_b_q, alu_b_d;
    logic [1:0] alu_op_q, alu_op_d;
    logic       res_valid_q, res_valid_d;
    logic [3:0] res_data_q, res_data_d;
    logic       res_id_q, res_id_d;
    logic       last_grant_q, last_grant_d;

    logic       any_valid_s;
    logic       both_valid_s;
    logic       grant_idx_s;
    logic       req0_ready_s;
    logic       req1_ready_s;
    logic       accept_s;
    logic [3:0] grant_a_s;
    logic [3:0] grant_b_s;
    logic [1:0] grant_op_s;

    // Arbitration: pick which requester would be granted if we are in IDLE.
    always_comb begin
        both_valid_s = bus.req0_valid & bus.req1_valid;
        any_valid_s  = bus.req0_valid | bus.req1_valid;
        grant_idx_s  = 1'b0;
        if (both_valid_s) begin
            // last_grant resets to 1 so requester 0 wins the first contention
            if (RR_EN) begin
                grant_idx_s = ~last_grant_q;
            end else begin
                grant_idx_s = 1'b0;
            end
        end else if (bus.req1_valid) begin
            grant_idx_s = 1'b1;
        end else begin
            grant_idx_s = 1'b0;
        end
    end

    // Ready is combinational and only ever asserted in IDLE outside reset.
    always_comb begin
        req0_ready_s = 1'b0;
        req1_ready_s = 1'b0;
        if (rst_n && (state_q == ST_IDLE) && any_valid_s) begin
            if (grant_idx_s) begin
                req1_ready_s = 1'b1;
            end else begin
                req0_ready_s = 1'b1;
            end
        end else begin
            req0_ready_s = 1'b0;
            req1_ready_s = 1'b0;
        end
        accept_s = req0_ready_s | req1_ready_s;
    end

    // Operand mux for the granted requester.
    always_comb begin
        grant_a_s  = 4'd0;
        grant_b_s  = 4'd0;
        grant_op_s = 2'b00;
        if (grant_idx_s) begin
            grant_a_s  = bus.req1_a;
            grant_b_s  = bus.req1_b;
            grant_op_s = bus.req1_op;
        end else begin
            grant_a_s  = bus.req0_a;
            grant_b_s  = bus.req0_b;
            grant_op_s = bus.req0_op;
        end
    end

    // Next-state and register-load logic of the operation FSM.
    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        res_id_d     = res_id_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    alu_a_d      = grant_a_s;
                    alu_b_d      = grant_b_s;
                    alu_op_d     = grant_op_s;
                    res_id_d     = grant_idx_s;
                    last_grant_d = grant_idx_s;
                    state_d      = ST_EXEC;
                end else begin
                    state_d      = ST_IDLE;
                end
            end
            ST_EXEC: begin
                // Operands stay in alu_*_q while the ALU registers its result
                state_d = ST_CAPT;
            end
            ST_CAPT: begin
                // Only state in which alu_out is defined (ALU has no reset)
                res_data_d  = bus.alu_out;
                res_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d     = ST_RESP;
                end
            end
            default: begin
                res_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            alu_a_q      <= 4'd0;
            alu_b_q      <= 4'd0;
            alu_op_q     <= 2'b00;
            res_valid_q  <= 1'b0;
            res_data_q   <= 4'd0;
            res_id_q     <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_id_q     <= res_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.req0_ready = req0_ready_s;
    assign bus.req1_ready = req1_ready_s;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_op     = alu_op_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_data   = res_data_q;
    assign bus.res_id     = res_id_q;
    assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//   Two arbiters (round-robin and fixed priority), each with a registered ALU
//   model. Directed stimulus pushes hand-computed {id,data} results into a
//   per-instance queue; a monitor pops and compares on every result handshake.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    logic clk = 1'b0;
    logic rst_n_a = 1'b0;
    logic rst_n_b = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0] q_a[$];
    logic [4:0] q_b[$];
    logic [9:0] tab0[8];
    logic [9:0] tab1[8];

    alu_arbiter_if if_a ();
    alu_arbiter_if if_b ();

    alu_arbiter #(.RR_EN(1'b1)) dut_a (.clk(clk), .rst_n(rst_n_a), .bus(if_a));
    alu_arbiter #(.RR_EN(1'b0)) dut_b (.clk(clk), .rst_n(rst_n_b), .bus(if_b));

    always #5 clk = ~clk;

    function automatic logic [3:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                          input logic [1:0] op);
        case (op)
            2'b00:   alu_fn = a + b;
            2'b01:   alu_fn = a - b;
            2'b10:   alu_fn = a & b;
            default: alu_fn = a | b;
        endcase
    endfunction

    // External registered ALUs (no reset).
    always @(posedge clk) begin
        if_a.alu_out <= alu_fn(if_a.alu_a, if_a.alu_b, if_a.alu_op);
        if_b.alu_out <= alu_fn(if_b.alu_a, if_b.alu_b, if_b.alu_op);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Result monitors: pop expected entry on every result handshake.
    always @(negedge clk) begin
        if (if_a.res_valid && if_a.res_ready) begin
            if (q_a.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL a_unexpected_result: got id=%0d data=0x%0h expected none",
                         if_a.res_id, if_a.res_data);
            end else begin
                chk("a_result", {27'd0, if_a.res_id, if_a.res_data}, {27'd0, q_a.pop_front()});
            end
        end
        if (if_b.res_valid && if_b.res_ready) begin
            if (q_b.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL b_unexpected_result: got id=%0d data=0x%0h expected none",
                         if_b.res_id, if_b.res_data);
            end else begin
                chk("b_result", {27'd0, if_b.res_id, if_b.res_data}, {27'd0, q_b.pop_front()});
            end
        end
    end

    task automatic reset_a();
        rst_n_a = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 rst_n_a = 1'b1;
    endtask

    task automatic wait_drain_a();
        int k = 0;
        while (q_a.size() != 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("a_queue_drained", q_a.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Both requesters present table entries back to back while they have any.
    task automatic drive_a(input int n0, input int n1);
        int   i0  = 0;
        int   i1  = 0;
        int   cyc = 0;
        logic g0, g1;
        @(posedge clk);
        #1;
        if (n0 > 0) begin
            {if_a.req0_a, if_a.req0_b, if_a.req0_op} = tab0[0];
            if_a.req0_valid = 1'b1;
        end
        if (n1 > 0) begin
            {if_a.req1_a, if_a.req1_b, if_a.req1_op} = tab1[0];
            if_a.req1_valid = 1'b1;
        end
        while ((i0 < n0 || i1 < n1) && cyc < 400) begin
            @(negedge clk);
            g0 = if_a.req0_ready;
            g1 = if_a.req1_ready;
            chk("a_ready_onehot", {31'd0, g0 & g1}, 0);
            @(posedge clk);
            #1;
            if (g0) begin
                i0++;
                if (i0 < n0) {if_a.req0_a, if_a.req0_b, if_a.req0_op} = tab0[i0];
                else if_a.req0_valid = 1'b0;
            end
            if (g1) begin
                i1++;
                if (i1 < n1) {if_a.req1_a, if_a.req1_b, if_a.req1_op} = tab1[i1];
                else if_a.req1_valid = 1'b0;
            end
            cyc++;
        end
        chk("a_all_accepted", {31'd0, (i0 == n0) && (i1 == n1)}, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   k;
        int   g;
        logic found;
        logic acc;

        if_a.req0_valid = 1'b1;  // held during reset: ready must stay low
        if_a.req1_valid = 1'b0;
        if_a.req0_a = 4'd0; if_a.req0_b = 4'd0; if_a.req0_op = 2'b00;
        if_a.req1_a = 4'd0; if_a.req1_b = 4'd0; if_a.req1_op = 2'b00;
        if_a.res_ready = 1'b1;
        if_b.req0_valid = 1'b0; if_b.req1_valid = 1'b0;
        if_b.req0_a = 4'd0; if_b.req0_b = 4'd0; if_b.req0_op = 2'b00;
        if_b.req1_a = 4'd0; if_b.req1_b = 4'd0; if_b.req1_op = 2'b00;
        if_b.res_ready = 1'b1;

        // ---- Reset state ----
        repeat (2) @(negedge clk);
        chk("rst_busy",      {31'd0, if_a.busy}, 0);
        chk("rst_res_valid", {31'd0, if_a.res_valid}, 0);
        chk("rst_res_data",  {28'd0, if_a.res_data}, 0);
        chk("rst_res_id",    {31'd0, if_a.res_id}, 0);
        chk("rst_alu_a",     {28'd0, if_a.alu_a}, 0);
        chk("rst_alu_b",     {28'd0, if_a.alu_b}, 0);
        chk("rst_alu_op",    {30'd0, if_a.alu_op}, 0);
        chk("rst_req0_ready", {31'd0, if_a.req0_ready}, 0);
        if_a.req0_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;

        // ---- ADD 7+9 wraps to 0, latency and ready pulse ----
        @(posedge clk);
        #1;
        if_a.req0_a = 4'h7; if_a.req0_b = 4'h9; if_a.req0_op = 2'b00; if_a.req0_valid = 1'b1;
        q_a.push_back({1'b0, 4'h0});
        @(negedge clk);
        chk("add_req0_ready", {31'd0, if_a.req0_ready}, 1);
        chk("add_req1_ready", {31'd0, if_a.req1_ready}, 0);
        @(negedge clk);
        k = 1;
        chk("add_ready_pulse", {31'd0, if_a.req0_ready}, 0);
        chk("add_busy",        {31'd0, if_a.busy}, 1);
        chk("add_alu_a",       {28'd0, if_a.alu_a}, 32'h7);
        chk("add_alu_b",       {28'd0, if_a.alu_b}, 32'h9);
        found = if_a.res_valid;
        @(posedge clk);
        #1 if_a.req0_valid = 1'b0;
        while (!found && k < 10) begin
            @(negedge clk);
            k++;
            found = if_a.res_valid;
        end
        chk("add_latency", k, 3);
        wait_drain_a();
        chk("add_back_idle", {31'd0, if_a.busy}, 0);

        // ---- Contention after reset: req0 SUB 3-5, req1 AND C&A ----
        reset_a();
        tab0[0] = {4'h3, 4'h5, 2'b01};
        tab1[0] = {4'hC, 4'hA, 2'b10};
        q_a.push_back({1'b0, 4'hE});
        q_a.push_back({1'b1, 4'h8});
        drive_a(1, 1);
        wait_drain_a();

        // ---- Stall in RESP for 5 cycles, req0 waiting behind it ----
        if_a.res_ready = 1'b0;
        if_a.req1_a = 4'hF; if_a.req1_b = 4'h3; if_a.req1_op = 2'b00; if_a.req1_valid = 1'b1;
        q_a.push_back({1'b1, 4'h2});
        q_a.push_back({1'b0, 4'h9});
        @(negedge clk);
        chk("stall_req1_ready", {31'd0, if_a.req1_ready}, 1);
        @(posedge clk);
        #1;
        if_a.req1_valid = 1'b0;
        if_a.req0_a = 4'h1; if_a.req0_b = 4'h8; if_a.req0_op = 2'b11; if_a.req0_valid = 1'b1;
        k = 0;
        found = 1'b0;
        while (!found && k < 10) begin
            @(negedge clk);
            k++;
            found = if_a.res_valid;
        end
        for (int i = 0; i < 5; i++) begin
            chk("stall_res_valid", {31'd0, if_a.res_valid}, 1);
            chk("stall_res_data",  {28'd0, if_a.res_data}, 32'h2);
            chk("stall_res_id",    {31'd0, if_a.res_id}, 1);
            chk("stall_busy",      {31'd0, if_a.busy}, 1);
            chk("stall_ready0",    {31'd0, if_a.req0_ready}, 0);
            chk("stall_ready1",    {31'd0, if_a.req1_ready}, 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 if_a.res_ready = 1'b1;
        @(negedge clk);
        chk("stall_hs_ready0", {31'd0, if_a.req0_ready}, 0);
        @(negedge clk);
        chk("next_accept_ready0", {31'd0, if_a.req0_ready}, 1);
        @(posedge clk);
        #1 if_a.req0_valid = 1'b0;
        wait_drain_a();

        // ---- Reset during EXEC of req1 OR 5|2 ----
        reset_a();
        @(posedge clk);
        #1;
        if_a.req1_a = 4'h5; if_a.req1_b = 4'h2; if_a.req1_op = 2'b11; if_a.req1_valid = 1'b1;
        @(negedge clk);
        chk("midrst_accept", {31'd0, if_a.req1_ready}, 1);
        @(posedge clk);
        #1 if_a.req1_valid = 1'b0;
        @(negedge clk);
        chk("midrst_exec_busy", {31'd0, if_a.busy}, 1);
        rst_n_a = 1'b0;
        #1;
        chk("midrst_busy",      {31'd0, if_a.busy}, 0);
        chk("midrst_res_valid", {31'd0, if_a.res_valid}, 0);
        chk("midrst_ready1",    {31'd0, if_a.req1_ready}, 0);
        @(posedge clk);
        #1 rst_n_a = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("midrst_no_result", {31'd0, if_a.res_valid}, 0);
        end

        // ---- Round-robin alternation over 6 operations ----
        tab0[0] = {4'h1, 4'h2, 2'b00};
        tab0[1] = {4'hF, 4'h6, 2'b10};
        tab0[2] = {4'h8, 4'h8, 2'b00};
        tab1[0] = {4'h0, 4'h1, 2'b01};
        tab1[1] = {4'h8, 4'h4, 2'b11};
        tab1[2] = {4'h9, 4'h2, 2'b01};
        q_a.push_back({1'b0, 4'h3});
        q_a.push_back({1'b1, 4'hF});
        q_a.push_back({1'b0, 4'h6});
        q_a.push_back({1'b1, 4'hC});
        q_a.push_back({1'b0, 4'h0});
        q_a.push_back({1'b1, 4'h7});
        drive_a(3, 3);
        wait_drain_a();

        // ---- Fixed priority: requester 0 wins 4 times, req1 never ready ----
        tab0[0] = {4'h1, 4'h1, 2'b00};
        tab0[1] = {4'h2, 4'h7, 2'b01};
        tab0[2] = {4'h7, 4'h5, 2'b10};
        tab0[3] = {4'h2, 4'h4, 2'b11};
        q_b.push_back({1'b0, 4'h2});
        q_b.push_back({1'b0, 4'hB});
        q_b.push_back({1'b0, 4'h5});
        q_b.push_back({1'b0, 4'h6});
        @(posedge clk);
        #1;
        {if_b.req0_a, if_b.req0_b, if_b.req0_op} = tab0[0];
        if_b.req0_valid = 1'b1;
        if_b.req1_a = 4'hF; if_b.req1_b = 4'hF; if_b.req1_op = 2'b00; if_b.req1_valid = 1'b1;
        g = 0;
        k = 0;
        while (g < 4 && k < 200) begin
            @(negedge clk);
            chk("fp_req1_never_ready", {31'd0, if_b.req1_ready}, 0);
            acc = if_b.req0_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                g++;
                if (g < 4) begin
                    {if_b.req0_a, if_b.req0_b, if_b.req0_op} = tab0[g];
                end else begin
                    if_b.req0_valid = 1'b0;
                    if_b.req1_valid = 1'b0;
                end
            end
            k++;
        end
        chk("fp_grants_req0", g, 4);
        k = 0;
        while (q_b.size() != 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("b_queue_drained", q_b.size(), 0);
        repeat (4) @(negedge clk);
        chk("b_idle_at_end", {31'd0, if_b.busy}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
